// File: rtl/interconnect_pkg.sv
// Shared types and helpers for the MMIO interconnect: FSM state encoding and
// the slot-select width calculation used by the decoder, bus interface and top.
package interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Slot-select field width; a single slot still consumes one address bit.
  function automatic int unsigned sel_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_interconnect_if.sv
// CPU data-port bus plus the shared peripheral-slot bus seen by the interconnect.
// The slave modport is the interconnect's view; master is the CPU/peripheral side.
interface mmio_interconnect_if #(
  parameter int unsigned NumSlaves = 4,
  parameter int unsigned AddrWidth = 30,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned SelW = interconnect_pkg::sel_bits(NumSlaves);
  localparam int unsigned OffW = AddrWidth - SelW;
  localparam int unsigned BeW  = DataWidth / 8;

  logic                           m_req_i;
  logic                           m_we_i;
  logic [AddrWidth-1:0]           m_addr_i;
  logic [DataWidth-1:0]           m_wdata_i;
  logic [BeW-1:0]                 m_be_i;
  logic                           m_ack_o;
  logic                           m_err_o;
  logic [DataWidth-1:0]           m_rdata_o;
  logic                           m_busy_o;

  logic [NumSlaves-1:0]           s_req_o;
  logic                           s_we_o;
  logic [OffW-1:0]                s_addr_o;
  logic [DataWidth-1:0]           s_wdata_o;
  logic [BeW-1:0]                 s_be_o;
  logic [NumSlaves-1:0]           s_ack_i;
  logic [NumSlaves*DataWidth-1:0] s_rdata_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, m_be_i,
    output m_ack_o, m_err_o, m_rdata_o, m_busy_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o,
    input  s_ack_i, s_rdata_i
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, m_be_i,
    input  m_ack_o, m_err_o, m_rdata_o, m_busy_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o,
    output s_ack_i, s_rdata_i
  );

endinterface

// File: rtl/mmio_slot_decoder.sv
// Combinational slot decode: the top address bits select a slot, and any
// index at or beyond the populated slot count is reported as unmapped.
module mmio_slot_decoder
  import interconnect_pkg::*;
#(
  parameter int unsigned NumSlaves = 4,
  parameter int unsigned AddrWidth = 30
) (
  input  logic [AddrWidth-1:0]             addr,
  output logic [sel_bits(NumSlaves)-1:0]   idx,
  output logic                             mapped
);
  localparam int unsigned     SelW      = sel_bits(NumSlaves);
  localparam logic [SelW:0]   SlotCount = (SelW + 1)'(NumSlaves);

  // Offset bits are latched by the top; the decoder only looks at the select field.
  logic unused_low;
  assign unused_low = ^addr[AddrWidth-SelW-1:0];

  assign idx    = addr[AddrWidth-1 -: SelW];
  assign mapped = ({1'b0, idx} < SlotCount);

endmodule

// File: rtl/mmio_interconnect.sv
// Single-master MMIO interconnect: decodes a slot from the top address bits,
// runs a registered req/ack handshake with timeout, and returns read data.
module mmio_interconnect
  import interconnect_pkg::*;
#(
  parameter int unsigned NumSlaves     = 4,
  parameter int unsigned AddrWidth     = 30,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input logic                clk,
  input logic                rst,
  mmio_interconnect_if.slave bus
);
  localparam int unsigned     SelW     = sel_bits(NumSlaves);
  localparam int unsigned     OffW     = AddrWidth - SelW;
  localparam int unsigned     BeW      = DataWidth / 8;
  localparam int unsigned     CntW     = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

  state_e               state;
  logic [SelW-1:0]      idx_q;
  logic [CntW-1:0]      cnt_q;
  logic                 ack_q;
  logic                 err_q;
  logic                 busy_q;
  logic [DataWidth-1:0] rdata_q;
  logic [NumSlaves-1:0] req_q;
  logic                 we_q;
  logic [OffW-1:0]      addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [BeW-1:0]       be_q;

  logic [SelW-1:0]      dec_idx;
  logic                 dec_mapped;
  logic                 slot_ack;
  logic [DataWidth-1:0] cap_data;
  logic                 timeout_hit;

  mmio_slot_decoder #(
    .NumSlaves (NumSlaves),
    .AddrWidth (AddrWidth)
  ) u_dec (
    .addr   (bus.m_addr_i),
    .idx    (dec_idx),
    .mapped (dec_mapped)
  );

  // Only the latched slot is ever listened to; other slots' acks never matter.
  assign slot_ack    = bus.s_ack_i[idx_q];
  assign cap_data    = we_q ? '0 : bus.s_rdata_i[idx_q*DataWidth +: DataWidth];
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLimit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      req_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      req_q <= '0;
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.m_req_i) begin
            busy_q <= 1'b1;
            if (dec_mapped) begin
              state   <= ISSUE;
              idx_q   <= dec_idx;
              cnt_q   <= '0;
              req_q   <= NumSlaves'(1) << dec_idx;
              we_q    <= bus.m_we_i;
              addr_q  <= bus.m_addr_i[OffW-1:0];
              wdata_q <= bus.m_wdata_i;
              be_q    <= bus.m_be_i;
            end else begin
              state   <= RESP;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (slot_ack) begin
            state   <= RESP;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= cap_data;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // A real ack wins over a timeout landing in the same cycle.
          if (slot_ack) begin
            state   <= RESP;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= cap_data;
          end else if (timeout_hit) begin
            state   <= RESP;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          err_q  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_ack_o   = ack_q;
  assign bus.m_err_o   = err_q;
  assign bus.m_rdata_o = rdata_q;
  assign bus.m_busy_o  = busy_q;
  assign bus.s_req_o   = req_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_addr_o  = addr_q;
  assign bus.s_wdata_o = wdata_q;
  assign bus.s_be_o    = be_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Bench for mmio_interconnect: directed scenarios plus randomized transactions
// on a 4-slot instance, and unmapped-address behaviour on a 3-slot instance.
module tb_mmio_interconnect;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  mmio_interconnect_if #(.NumSlaves(4), .AddrWidth(30), .DataWidth(32)) bus4 ();
  mmio_interconnect_if #(.NumSlaves(3), .AddrWidth(30), .DataWidth(32)) bus3 ();

  mmio_interconnect #(
    .NumSlaves(4), .AddrWidth(30), .DataWidth(32), .TimeoutCycles(TO)
  ) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  mmio_interconnect #(
    .NumSlaves(3), .AddrWidth(30), .DataWidth(32), .TimeoutCycles(4)
  ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference timing: an ack n cycles after the strobe completes n+1 cycles after it,
  // as long as it lands inside the wait window; otherwise the timeout fires.
  function automatic int ref_ack_cycle(input int delay);
    return (delay >= 0 && delay <= int'(TO) + 1) ? delay + 2 : int'(TO) + 3;
  endfunction

  // One transaction on the 4-slot bus. delay = cycles from strobe to slave ack
  // (anything beyond the window means the ack arrives late or never).
  task automatic txn(input string tag, input logic we, input logic [29:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int delay,
                     input logic [31:0] rdata, input logic [3:0] spur_mask,
                     input int spur_cycle);
    int          slot      = int'(addr[29:28]);
    int          sreq_cyc  = -1;
    int          ack_cyc   = -1;
    int          acks      = 0;
    logic [3:0]  sreq_val  = '0;
    logic [27:0] saddr     = '0;
    logic        swe       = 1'b0;
    logic [31:0] swd       = '0;
    logic [3:0]  sbe       = '0;
    logic        err_seen  = 1'b0;
    logic [31:0] rd_seen   = '0;
    logic        busy1     = 1'b0;
    int          exp_ack   = ref_ack_cycle(delay);
    logic        exp_err   = (exp_ack == int'(TO) + 3) && !(delay == int'(TO) + 1);
    logic [31:0] exp_rd    = (exp_err || we) ? 32'h0 : rdata;

    @(negedge clk);
    bus4.m_req_i   = 1'b1;
    bus4.m_we_i    = we;
    bus4.m_addr_i  = addr;
    bus4.m_wdata_i = wdata;
    bus4.m_be_i    = be;
    for (int k = 1; k <= int'(TO) + 12; k++) begin
      @(negedge clk);
      bus4.m_req_i = 1'b0;
      if (k == 1) busy1 = bus4.m_busy_o;
      if (bus4.s_req_o != 4'b0) begin
        if (sreq_cyc == -1) begin
          sreq_cyc = k;
          sreq_val = bus4.s_req_o;
          saddr    = bus4.s_addr_o;
          swe      = bus4.s_we_o;
          swd      = bus4.s_wdata_o;
          sbe      = bus4.s_be_o;
        end else begin
          sreq_cyc = -2;
        end
      end
      if (bus4.m_ack_o) begin
        acks++;
        if (ack_cyc == -1) begin
          ack_cyc  = k;
          err_seen = bus4.m_err_o;
          rd_seen  = bus4.m_rdata_o;
        end
      end
      bus4.s_ack_i = 4'b0;
      if (delay >= 0 && k == 1 + delay) bus4.s_ack_i[slot] = 1'b1;
      if (k == spur_cycle) bus4.s_ack_i = bus4.s_ack_i | spur_mask;
      for (int j = 0; j < 4; j++)
        bus4.s_rdata_i[j*32 +: 32] = (j == slot) ? rdata : $urandom;
    end
    bus4.s_ack_i = 4'b0;

    check({tag, ".busy"},     64'(busy1), 64'(1));
    check({tag, ".sreq_cyc"}, 64'(sreq_cyc), 64'(1));
    check({tag, ".sreq"},     64'(sreq_val), 64'(4'b0001 << slot));
    check({tag, ".s_addr"},   64'(saddr), 64'(addr[27:0]));
    check({tag, ".s_we"},     64'(swe), 64'(we));
    check({tag, ".s_wdata"},  64'(swd), 64'(wdata));
    check({tag, ".s_be"},     64'(sbe), 64'(be));
    check({tag, ".acks"},     64'(acks), 64'(1));
    check({tag, ".ack_cyc"},  64'(ack_cyc), 64'(exp_ack));
    check({tag, ".err"},      64'(err_seen), 64'(exp_err));
    check({tag, ".rdata"},    64'(rd_seen), 64'(exp_rd));
    check({tag, ".hold"},     64'(bus4.m_rdata_o), 64'(exp_rd));
  endtask

  logic [1:0]  r_slot;
  logic        r_we;
  logic [31:0] r_wd;
  logic [31:0] r_rd;
  logic [3:0]  r_be;
  int          r_delay;
  logic [3:0]  r_spur;

  initial begin
    rst            = 1'b1;
    bus4.m_req_i   = 1'b0;
    bus4.m_we_i    = 1'b0;
    bus4.m_addr_i  = '0;
    bus4.m_wdata_i = '0;
    bus4.m_be_i    = '0;
    bus4.s_ack_i   = '0;
    bus4.s_rdata_i = '0;
    bus3.m_req_i   = 1'b0;
    bus3.m_we_i    = 1'b0;
    bus3.m_addr_i  = '0;
    bus3.m_wdata_i = '0;
    bus3.m_be_i    = '0;
    bus3.s_ack_i   = '0;
    bus3.s_rdata_i = '0;
    repeat (2) @(negedge clk);
    check("rst.m_ack",   64'(bus4.m_ack_o), 64'(0));
    check("rst.m_err",   64'(bus4.m_err_o), 64'(0));
    check("rst.m_busy",  64'(bus4.m_busy_o), 64'(0));
    check("rst.s_req",   64'(bus4.s_req_o), 64'(0));
    check("rst.m_rdata", 64'(bus4.m_rdata_o), 64'(0));
    check("rst.s_addr",  64'(bus4.s_addr_o), 64'(0));
    rst = 1'b0;

    // Zero-wait read from slot 1.
    txn("rd0", 1'b0, 30'h1000_0004, 32'h0, 4'hF, 0, 32'hCAFE_0001, 4'b0, 0);

    // Reset during WAIT of a write: outputs clear and a later slave ack is dropped.
    @(negedge clk);
    bus4.m_req_i   = 1'b1;
    bus4.m_we_i    = 1'b1;
    bus4.m_addr_i  = 30'h10AB_CDE0;
    bus4.m_wdata_i = 32'hDEAD_BEEF;
    bus4.m_be_i    = 4'hF;
    @(negedge clk);
    bus4.m_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst.m_ack",   64'(bus4.m_ack_o), 64'(0));
    check("mrst.m_busy",  64'(bus4.m_busy_o), 64'(0));
    check("mrst.s_req",   64'(bus4.s_req_o), 64'(0));
    check("mrst.m_rdata", 64'(bus4.m_rdata_o), 64'(0));
    check("mrst.s_we",    64'(bus4.s_we_o), 64'(0));
    check("mrst.s_wdata", 64'(bus4.s_wdata_o), 64'(0));
    check("mrst.s_be",    64'(bus4.s_be_o), 64'(0));
    bus4.s_ack_i = 4'b0010;
    @(negedge clk);
    bus4.s_ack_i = 4'b0;
    check("mrst.late_ack", 64'(bus4.m_ack_o), 64'(0));
    check("mrst.idle",     64'(bus4.m_busy_o), 64'(0));
    @(negedge clk);
    check("mrst.late_ack2", 64'(bus4.m_ack_o), 64'(0));
    txn("post_rst", 1'b0, 30'h1000_0008, 32'h0, 4'hF, 2, 32'h0BAD_F00D, 4'b0, 0);

    // Write to slot 3 acked 5 cycles after the strobe.
    txn("wr3", 1'b1, 30'h3000_0010, 32'h1234_5678, 4'b0011, 5, 32'h5555_AAAA, 4'b0, 0);
    // Slot 2 never acks in time; its late ack must not produce a second response.
    txn("tmo2", 1'b0, 30'h2000_0020, 32'h0, 4'hF, int'(TO) + 4, 32'h7777_0002, 4'b0, 0);
    // Ack exactly on the last wait cycle still succeeds.
    txn("edge", 1'b0, 30'h2000_0024, 32'h0, 4'hF, int'(TO) + 1, 32'h8888_0002, 4'b0, 0);
    // Spurious ack from slot 1 while slot 0 is waiting.
    txn("spur", 1'b0, 30'h0000_0100, 32'h0, 4'hF, 6, 32'h0000_C0DE, 4'b0010, 3);

    for (int t = 0; t < 40; t++) begin
      r_slot  = 2'($urandom_range(0, 3));
      r_we    = 1'($urandom_range(0, 1));
      r_wd    = $urandom;
      r_rd    = $urandom | 32'h1;
      r_be    = 4'($urandom);
      r_delay = int'($urandom_range(0, 15));
      r_spur  = 4'($urandom) & ~(4'b0001 << r_slot);
      txn("rnd", r_we, {r_slot, 28'($urandom)}, r_wd, r_be, r_delay, r_rd, r_spur,
          int'($urandom_range(1, 14)));
    end

    // 3-slot instance: mapped zero-wait read of slot 2, then unmapped select value 3.
    @(negedge clk);
    bus3.m_req_i  = 1'b1;
    bus3.m_addr_i = 30'h2000_0010;
    @(negedge clk);
    bus3.m_req_i = 1'b0;
    check("n3.sreq",   64'(bus3.s_req_o), 64'(3'b100));
    check("n3.s_addr", 64'(bus3.s_addr_o), 64'(28'h10));
    bus3.s_ack_i   = 3'b100;
    bus3.s_rdata_i = {32'hA5A5_0002, 32'h1111_1111, 32'h2222_2222};
    @(negedge clk);
    bus3.s_ack_i = 3'b0;
    check("n3.ack",   64'(bus3.m_ack_o), 64'(1));
    check("n3.err",   64'(bus3.m_err_o), 64'(0));
    check("n3.rdata", 64'(bus3.m_rdata_o), 64'(32'hA5A5_0002));
    @(negedge clk);
    check("n3.ack_end", 64'(bus3.m_ack_o), 64'(0));
    bus3.m_req_i  = 1'b1;
    bus3.m_addr_i = 30'h3000_0000;
    @(negedge clk);
    bus3.m_req_i = 1'b0;
    check("unm.ack",   64'(bus3.m_ack_o), 64'(1));
    check("unm.err",   64'(bus3.m_err_o), 64'(1));
    check("unm.sreq",  64'(bus3.s_req_o), 64'(0));
    check("unm.rdata", 64'(bus3.m_rdata_o), 64'(0));
    check("unm.busy",  64'(bus3.m_busy_o), 64'(1));
    @(negedge clk);
    check("unm.ack_end", 64'(bus3.m_ack_o), 64'(0));
    check("unm.sreq2",   64'(bus3.s_req_o), 64'(0));
    check("unm.idle",    64'(bus3.m_busy_o), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed %0d/%0d checks", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmio_interconnect.md
# mmio_interconnect

Parametrised single-master memory-mapped interconnect that connects the CPU data port to N peripheral slots (RAM, UART, timers, GPIO, …). It generalises the fixed two-way RAM/IO split: it decodes a slot index from the top address bits, runs a registered request/acknowledge handshake with variable-latency slaves, and muxes read data back. It reports bus errors for unmapped addresses and for slave timeouts. It sits between `cpu` and all data-side slaves in the top level.

## Interface
- `NumSlaves`, 4: number of slots; must be ≥ 1.
- `AddrWidth`, 30: word address width.
- `DataWidth`, 32: data width; must be a multiple of 8.
- `TimeoutCycles`, 255: maximum WAIT cycles before an error response; 0 disables the timeout.
- `clk` in 1: single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `m_req_i` in 1: master request; sampled only in IDLE.
- `m_we_i` in 1: 1 = write, 0 = read.
- `m_addr_i` in AddrWidth: word address.
- `m_wdata_i` in DataWidth: write data.
- `m_be_i` in DataWidth/8: byte enables.
- `m_ack_o` out 1: one-cycle completion pulse.
- `m_err_o` out 1: valid with `m_ack_o`; 1 = unmapped address or timeout.
- `m_rdata_o` out DataWidth: read data; valid with `m_ack_o` and held until the next ack.
- `m_busy_o` out 1: high when the state is not IDLE.
- `s_req_o` out NumSlaves: one-hot, one-cycle request strobe.
- `s_we_o` out 1, `s_addr_o` out AddrWidth-SelBits, `s_wdata_o` out DataWidth, `s_be_o` out DataWidth/8: latched request, shared by all slots.
- `s_ack_i` in NumSlaves: per-slot completion.
- `s_rdata_i` in NumSlaves*DataWidth: slot k occupies bits [k*DataWidth +: DataWidth].

## Operation
- SelBits = max(1, $clog2(NumSlaves)). Slot index = `m_addr_i[AddrWidth-1 -: SelBits]`. The address is mapped if index < NumSlaves. `s_addr_o` carries the remaining low bits.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, `m_req_i`=1, mapped: latch we/addr/wdata/be and the slot index, then go to ISSUE.
- IDLE, `m_req_i`=1, unmapped: go to RESP with err=1 and rdata=0. No `s_req_o` is issued.
- ISSUE: `s_req_o[idx]`=1 for exactly this cycle. If `s_ack_i[idx]`=1, capture data and go to RESP. Otherwise go to WAIT.
- WAIT: on `s_ack_i[idx]`, capture data and go to RESP with err=0. If the counter reaches TimeoutCycles, go to RESP with err=1 and rdata=0.
- RESP: `m_ack_o`=1 (and `m_err_o` as computed) for one cycle, then go to IDLE.
- Captured data = `s_rdata_i[idx]` for reads, 0 for writes.
- Acks from non-selected slots are always ignored. A slave ack that arrives after a timeout, or while in IDLE, is ignored.
- `m_req_i` outside IDLE is ignored. The master waits for `m_busy_o`=0.
- The timeout counter is $clog2(TimeoutCycles+1) bits wide. It clears on entering ISSUE, increments each WAIT cycle, and saturates.

## Timing
- Reset values: state=IDLE; `m_ack_o`, `m_err_o`, `m_busy_o`, `s_req_o`, `s_we_o` = 0; `m_rdata_o`, `s_addr_o`, `s_wdata_o`, `s_be_o` = 0; counter = 0.
- Reset asserted mid-transaction forces IDLE on the next edge. No ack is produced and any pending slave ack is dropped.
- Mapped request, zero-wait slave: request in cycle 0, `s_req_o` in cycle 1, ack in cycle 1, `m_ack_o` in cycle 2. The next request is accepted in cycle 3.
- Slave ack in cycle 1+n gives `m_ack_o` in cycle 2+n.
- Unmapped request in cycle 0 gives `m_ack_o`/`m_err_o` in cycle 1.
- Timeout: with no ack, `m_ack_o`+`m_err_o` is asserted TimeoutCycles+2 cycles after `s_req_o`.
- All outputs are registered. There is no combinational path from `s_*_i` to `m_*_o`.

## Structure
- `interconnect_pkg`: FSM state enum (`state_e`) and the `SelBits` helper function.
- Sub-module `mmio_slot_decoder`: combinational; takes the address and outputs `idx` and `mapped`. Parametrised by NumSlaves and AddrWidth.

## Test plan
- Read, NumSlaves=4, addr 0x1000_0004 → `s_req_o`=4'b0010 in cycle 1 with `s_addr_o`=0x4. Slot 1 acks in cycle 1 with 0xCAFE_0001 → `m_ack_o` in cycle 2, `m_rdata_o`=0xCAFE_0001, `m_err_o`=0.
- Write to slot 3 with be=4'b0011 and data 0x1234_5678. Slot 3 acks 5 cycles after `s_req_o` → `m_ack_o` 6 cycles after `s_req_o`, `m_rdata_o`=0, `s_be_o`=4'b0011.
- NumSlaves=3, addr 0x3000_0000 → no `s_req_o`; `m_ack_o`=`m_err_o`=1 in cycle 1.
- TimeoutCycles=8, slot 2 never acks → err ack 10 cycles after `s_req_o`. A late ack from slot 2 afterwards produces no extra `m_ack_o`.
- Slot 0 selected, slot 1 acks spuriously in WAIT → ignored. Slot 0 acks later → single correct ack.
- `rst` pulsed in WAIT → outputs are 0 next cycle. A subsequent slave ack is ignored, and a new request completes normally.
